dt_param_engine: RTL and testbench

// - Two-pass distance transform engine. Binary image read from sti ROM, distance map read/written in res RAM.
// - Forward pass in raster order, then backward pass in reverse raster order.
// - Generalises the fixed 128x128 chessboard engine: image size, word and distance widths are parameters.
// - mode selects the metric: 0 = chessboard (8-neighbour), 1 = city-block (4-neighbour).
// - Adds start/done re-run support. Sits between testbench/top control and the sti/res memories.

---
 rtl/dt_param_engine_pkg.sv | 51 +++++
 rtl/dt_param_engine_if.sv | 38 +++
 rtl/dt_param_engine_nbr_min.sv | 29 ++
 rtl/dt_param_engine.sv | 211 +++++++++++++++++++++
 tb/tb_dt_param_engine.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/dt_param_engine_pkg.sv
// dt_param_engine_pkg
// Shared types for the two-pass distance transform engine:
//   - FSM state encoding
//   - metric select (chessboard / city-block)
//   - neighbour offset table, indexed by metric, pass and slot
// No ports (package).
package dt_param_engine_pkg;

  typedef enum logic [3:0] {
    IDLE, F_PX, F_NB, F_WR, F2B, B_PX, B_NB, B_WR, DONE
  } state_e;

  typedef enum logic {
    CHESS = 1'b0,
    CITY  = 1'b1
  } mode_e;

  // Row/column step as 2-bit two's complement: -1, 0 or +1.
  typedef struct packed {
    logic [1:0] dr;
    logic [1:0] dc;
  } nb_off_t;

  localparam int unsigned NB_SLOTS = 4;
  localparam logic [1:0]  OFF_M1   = 2'b11;
  localparam logic [1:0]  OFF_0    = 2'b00;
  localparam logic [1:0]  OFF_P1   = 2'b01;

  // Forward set: NW, N, NE, W (chessboard) or N, W (city-block).
  // The backward set is the point mirror of the forward set.
  function automatic nb_off_t nb_offset(input mode_e m, input logic bwd, input logic [1:0] slot);
    nb_off_t o;
    if (m == CITY) begin
      o.dr = slot[0] ? OFF_M1 : OFF_0;
      o.dc = slot[0] ? OFF_0  : OFF_M1;
    end else begin
      case (slot)
        2'd0:    begin o.dr = OFF_M1; o.dc = OFF_M1; end
        2'd1:    begin o.dr = OFF_M1; o.dc = OFF_0;  end
        2'd2:    begin o.dr = OFF_M1; o.dc = OFF_P1; end
        default: begin o.dr = OFF_0;  o.dc = OFF_M1; end
      endcase
    end
    if (bwd) begin
      o.dr = -o.dr;
      o.dc = -o.dc;
    end
    return o;
  endfunction

endpackage

// File: rtl/dt_param_engine_if.sv
// dt_param_engine_if
// Control and memory bus of the distance transform engine.
//   start/mode/done       : run control
//   sti_rd/sti_addr/sti_di: binary image ROM (one word = STI_W pixels, MSB leftmost)
//   res_*                 : distance map RAM, combinational read data
// Modports: master = controller/memory side, slave = engine.
interface dt_param_engine_if #(
  parameter int unsigned IMG_W = 128,
  parameter int unsigned IMG_H = 128,
  parameter int unsigned STI_W = 16,
  parameter int unsigned DW    = 8
);
  localparam int unsigned PA = $clog2(IMG_W * IMG_H);
  localparam int unsigned SA = PA - $clog2(STI_W);

  logic             start;
  logic             mode;
  logic             done;
  logic             sti_rd;
  logic [SA-1:0]    sti_addr;
  logic [STI_W-1:0] sti_di;
  logic             res_rd;
  logic             res_wr;
  logic [PA-1:0]    res_addr;
  logic [DW-1:0]    res_do;
  logic [DW-1:0]    res_di;

  modport master (
    output start, mode, sti_di, res_di,
    input  done, sti_rd, sti_addr, res_rd, res_wr, res_addr, res_do
  );

  modport slave (
    input  start, mode, sti_di, res_di,
    output done, sti_rd, sti_addr, res_rd, res_wr, res_addr, res_do
  );

endinterface

// File: rtl/dt_param_engine_nbr_min.sv
// dt_param_engine_nbr_min
// Minimum of four neighbour distances plus one, saturating at DMAX.
//   nb0_i..nb3_i : neighbour distances (unused slots tied to DMAX by the caller)
//   sat_o        : sat(min + 1), the +1 done in DW+1 bits so DMAX never wraps to 0
module dt_param_engine_nbr_min #(
  parameter int unsigned DW = 8
) (
  input  logic [DW-1:0] nb0_i,
  input  logic [DW-1:0] nb1_i,
  input  logic [DW-1:0] nb2_i,
  input  logic [DW-1:0] nb3_i,
  output logic [DW-1:0] sat_o
);
  localparam logic [DW-1:0] DMAX = {DW{1'b1}};

  logic [DW-1:0] m01;
  logic [DW-1:0] m23;
  logic [DW-1:0] m_all;
  logic [DW:0]   inc;

  always_comb begin
    m01   = (nb0_i < nb1_i) ? nb0_i : nb1_i;
    m23   = (nb2_i < nb3_i) ? nb2_i : nb3_i;
    m_all = (m01 < m23) ? m01 : m23;
    inc   = {1'b0, m_all} + {{DW{1'b0}}, 1'b1};
    sat_o = (inc >= {1'b0, DMAX}) ? DMAX : inc[DW-1:0];
  end

endmodule

// File: rtl/dt_param_engine.sv
// dt_param_engine
// Two-pass distance transform: forward raster pass reads the binary image and
// writes a first-pass map, backward pass refines it in place.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : start/mode/done control, sti ROM read port, res RAM read/write port
//
// state | meaning
// IDLE  | after reset, waiting for start
// F_PX  | forward: fetch object bit from sti
// F_NB  | forward: read one neighbour slot per cycle (K cycles)
// F_WR  | forward: write 0 or sat(min+1)
// F2B   | turnaround, index set to last pixel
// B_PX  | backward: read current distance, skip background
// B_NB  | backward: read one mirrored neighbour slot per cycle (K cycles)
// B_WR  | backward: write min(cur, sat(min+1))
// DONE  | map complete, done high, waiting for start
module dt_param_engine
  import dt_param_engine_pkg::*;
#(
  parameter int unsigned IMG_W = 128,
  parameter int unsigned IMG_H = 128,
  parameter int unsigned STI_W = 16,
  parameter int unsigned DW    = 8
) (
  input logic              clk,
  input logic              reset,
  dt_param_engine_if.slave bus
);
  localparam int unsigned   PA   = $clog2(IMG_W * IMG_H);
  localparam int unsigned   LW   = $clog2(IMG_W);
  localparam int unsigned   LH   = $clog2(IMG_H);
  localparam int unsigned   LS   = $clog2(STI_W);
  localparam logic [DW-1:0] DMAX = {DW{1'b1}};
  localparam logic [PA-1:0] LAST = PA'(IMG_W * IMG_H - 1);

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [PA-1:0] idx_q, idx_d;
  logic [1:0]    slot_q, slot_d;   // down-counter, slot 0 is the last one
  logic          obj_q, obj_d;
  logic [DW-1:0] cur_q, cur_d;
  logic [DW-1:0] nb_q [NB_SLOTS];
  logic [DW-1:0] nb_d [NB_SLOTS];
  logic [PA-1:0] res_addr_q, res_addr_d;

  logic          in_img_cur;
  logic          px_obj;
  logic [1:0]    k_last;
  logic [DW-1:0] nb_sat;
  logic [DW-1:0] nb2_in, nb3_in;

  function automatic logic nb_in_img(input logic [PA-1:0] idx, input nb_off_t off);
    logic [LH-1:0] row;
    logic [LW-1:0] col;
    row = idx[PA-1:LW];
    col = idx[LW-1:0];
    return !((off.dr == OFF_M1 && row == '0) ||
             (off.dr == OFF_P1 && row == LH'(IMG_H - 1)) ||
             (off.dc == OFF_M1 && col == '0) ||
             (off.dc == OFF_P1 && col == LW'(IMG_W - 1)));
  endfunction

  // Row and column are stepped separately so a column step never carries into the row.
  function automatic logic [PA-1:0] nb_addr(input logic [PA-1:0] idx, input nb_off_t off);
    logic [LH-1:0] row;
    logic [LW-1:0] col;
    row = idx[PA-1:LW];
    col = idx[LW-1:0];
    if (off.dr == OFF_M1)      row = row - LH'(1);
    else if (off.dr == OFF_P1) row = row + LH'(1);
    if (off.dc == OFF_M1)      col = col - LW'(1);
    else if (off.dc == OFF_P1) col = col + LW'(1);
    return {row, col};
  endfunction

  assign in_img_cur = nb_in_img(idx_q, nb_offset(mode_q, state_q == B_NB, slot_q));
  // ~x == STI_W-1-x for the in-word pixel position: MSB is the leftmost pixel.
  assign px_obj     = bus.sti_di[~idx_q[LS-1:0]];
  assign k_last     = (mode_q == CITY) ? 2'd1 : 2'd3;

  assign nb2_in = (mode_q == CITY) ? DMAX : nb_q[2];
  assign nb3_in = (mode_q == CITY) ? DMAX : nb_q[3];

  dt_param_engine_nbr_min #(.DW(DW)) u_nbr_min (
    .nb0_i (nb_q[0]),
    .nb1_i (nb_q[1]),
    .nb2_i (nb2_in),
    .nb3_i (nb3_in),
    .sat_o (nb_sat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      mode_q     <= CHESS;
      idx_q      <= '0;
      slot_q     <= '0;
      obj_q      <= 1'b0;
      cur_q      <= '0;
      nb_q       <= '{default: DMAX};
      res_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      slot_q     <= slot_d;
      obj_q      <= obj_d;
      cur_q      <= cur_d;
      nb_q       <= nb_d;
      res_addr_q <= res_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    slot_d  = slot_q;
    obj_d   = obj_q;
    cur_d   = cur_q;
    nb_d    = nb_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = F_PX;
          idx_d   = '0;
          mode_d  = mode_e'(bus.mode);
        end
      end
      F_PX: begin
        obj_d   = px_obj;
        slot_d  = k_last;
        state_d = px_obj ? F_NB : F_WR;
      end
      F_NB, B_NB: begin
        nb_d[slot_q] = in_img_cur ? bus.res_di : DMAX;
        if (slot_q == 2'd0) state_d = (state_q == F_NB) ? F_WR : B_WR;
        else                slot_d  = slot_q - 2'd1;
      end
      F_WR: begin
        if (idx_q == LAST) begin
          state_d = F2B;
        end else begin
          idx_d   = idx_q + PA'(1);
          state_d = F_PX;
        end
      end
      F2B: begin
        idx_d   = LAST;
        state_d = B_PX;
      end
      B_PX: begin
        cur_d = bus.res_di;
        if (bus.res_di == '0) begin
          if (idx_q == '0) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q - PA'(1);
            state_d = B_PX;
          end
        end else begin
          slot_d  = k_last;
          state_d = B_NB;
        end
      end
      B_WR: begin
        if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q - PA'(1);
          state_d = B_PX;
        end
      end
      default: state_d = IDLE;
    endcase

    // The RAM address is a register, so it is prepared for the cycle being entered.
    if (state_d == F_NB || state_d == B_NB)
      res_addr_d = nb_addr(idx_d, nb_offset(mode_d, state_d == B_NB, slot_d));
    else
      res_addr_d = idx_d;
  end

  always_comb begin
    bus.done   = 1'b0;
    bus.sti_rd = 1'b0;
    bus.res_rd = 1'b0;
    bus.res_wr = 1'b0;
    bus.res_do = '0;
    case (state_q)
      F_PX:       bus.sti_rd = 1'b1;
      F_NB, B_NB: bus.res_rd = in_img_cur;
      B_PX:       bus.res_rd = 1'b1;
      F_WR: begin
        bus.res_wr = 1'b1;
        bus.res_do = obj_q ? nb_sat : '0;
      end
      B_WR: begin
        bus.res_wr = 1'b1;
        bus.res_do = (cur_q < nb_sat) ? cur_q : nb_sat;
      end
      DONE:       bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.sti_addr = idx_q[PA-1:LS];
  assign bus.res_addr = res_addr_q;

endmodule

// File: tb/tb_dt_param_engine.sv
// tb_dt_param_engine
// Directed bench: 32x32/DW=8 engine for shape, border, reset and re-run cases,
// 16x16/DW=3 engine for the saturation case. ROM and RAM are simple arrays.
module tb_dt_param_engine;
  localparam int W  = 32;
  localparam int H  = 32;
  localparam int SW = 16;
  localparam int NP = W * H;
  localparam int WB = 16;
  localparam int NB = WB * WB;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dt_param_engine_if #(.IMG_W(W), .IMG_H(H), .STI_W(SW), .DW(8)) bus_a ();
  dt_param_engine_if #(.IMG_W(WB), .IMG_H(WB), .STI_W(SW), .DW(3)) bus_b ();

  dt_param_engine #(.IMG_W(W), .IMG_H(H), .STI_W(SW), .DW(8)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  dt_param_engine #(.IMG_W(WB), .IMG_H(WB), .STI_W(SW), .DW(3)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  logic [SW-1:0] sti_a [NP/SW];
  logic [7:0]    res_a [NP];
  logic [SW-1:0] sti_b [NB/SW];
  logic [2:0]    res_b [NB];

  assign bus_a.sti_di = sti_a[bus_a.sti_addr];
  assign bus_a.res_di = res_a[bus_a.res_addr];
  assign bus_b.sti_di = sti_b[bus_b.sti_addr];
  assign bus_b.res_di = res_b[bus_b.res_addr];

  always @(posedge clk) begin
    if (bus_a.res_wr) res_a[bus_a.res_addr] <= bus_a.res_do;
    if (bus_b.res_wr) res_b[bus_b.res_addr] <= bus_b.res_do;
  end

  int ovl_a = 0;
  int dox_a = 0;
  int rd_a  = 0;
  int wr_a  = 0;
  always @(negedge clk) begin
    if (int'(bus_a.sti_rd) + int'(bus_a.res_rd) + int'(bus_a.res_wr) > 1) ovl_a++;
    if (!bus_a.res_wr && bus_a.res_do != 8'd0) dox_a++;
    if (bus_a.res_rd) rd_a++;
    if (bus_a.res_wr) wr_a++;
  end

  int n_chk = 0;
  int n_err = 0;
  bit img_a [NP];
  int exp_a [NP];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cyc(input int npix, input int nobj, input int k);
    return 2 * (npix - nobj) + (k + 2) * nobj + 1 + (npix - nobj) + (k + 2) * nobj;
  endfunction

  task automatic clear_img();
    for (int i = 0; i < NP; i++) begin
      img_a[i] = 1'b0;
      exp_a[i] = 0;
    end
  endtask

  task automatic put(input int r, input int c, input int v);
    img_a[r * W + c] = 1'b1;
    exp_a[r * W + c] = v;
  endtask

  task automatic pack_img();
    for (int w = 0; w < NP / SW; w++)
      for (int b = 0; b < SW; b++)
        sti_a[w][SW-1-b] = img_a[w * SW + b];
  endtask

  task automatic check_map(input string tag);
    int nmis;
    nmis = 0;
    for (int i = 0; i < NP; i++)
      if (int'(res_a[i]) != exp_a[i]) nmis++;
    chk({tag, " map mismatches"}, nmis, 0);
  endtask

  task automatic run_a(input logic m, input int exp_cyc, input string tag, input bit poke);
    int n, ovl0, dox0;
    ovl0 = ovl_a;
    dox0 = dox_a;
    @(negedge clk);
    bus_a.mode  = m;
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_a.mode  = ~m;
    n = 0;
    while (bus_a.done !== 1'b1 && n < exp_cyc + 50) begin
      @(posedge clk);
      #1;
      n++;
      if (poke) bus_a.start = (n == 200);
    end
    bus_a.start = 1'b0;
    chk({tag, " cycles"}, n, exp_cyc);
    chk({tag, " strobe overlap"}, ovl_a - ovl0, 0);
    chk({tag, " res_do nonzero idle"}, dox_a - dox0, 0);
    repeat (3) @(negedge clk);
    chk({tag, " done held"}, int'({bus_a.done, bus_a.sti_rd, bus_a.res_rd, bus_a.res_wr}), 8);
    check_map(tag);
  endtask

  initial begin
    int n, rd0, wr0, nmis;
    reset       = 1'b0;
    bus_a.start = 1'b0;
    bus_a.mode  = 1'b0;
    bus_b.start = 1'b0;
    bus_b.mode  = 1'b0;
    for (int i = 0; i < NB / SW; i++) sti_b[i] = '1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset strobes", int'({bus_a.done, bus_a.sti_rd, bus_a.res_rd, bus_a.res_wr}), 0);
    chk("reset res_addr", int'(bus_a.res_addr), 0);
    chk("reset res_do", int'(bus_a.res_do), 0);

    clear_img();
    put(5, 5, 1);
    pack_img();
    run_a(1'b0, 3082, "single", 1'b0);
    chk("single px", int'(res_a[5 * W + 5]), 1);

    clear_img();
    for (int r = 10; r <= 12; r++)
      for (int c = 10; c <= 12; c++)
        put(r, c, (r == 11 && c == 11) ? 2 : 1);
    pack_img();
    run_a(1'b0, cyc(NP, 9, 4), "block chess", 1'b0);
    chk("block chess centre", int'(res_a[11 * W + 11]), 2);
    run_a(1'b1, cyc(NP, 9, 2), "block city", 1'b0);
    chk("block city centre", int'(res_a[11 * W + 11]), 2);

    clear_img();
    put(20, 20, 1); put(19, 20, 1); put(21, 20, 1); put(20, 19, 1); put(20, 21, 1);
    pack_img();
    run_a(1'b0, cyc(NP, 5, 4), "cross chess", 1'b0);
    chk("cross chess centre", int'(res_a[20 * W + 20]), 1);
    exp_a[20 * W + 20] = 2;
    run_a(1'b1, cyc(NP, 5, 2), "cross city", 1'b0);
    chk("cross city centre", int'(res_a[20 * W + 20]), 2);

    clear_img();
    put(0, 0, 1);
    put(H - 1, W - 1, 1);
    pack_img();
    rd0 = rd_a;
    wr0 = wr_a;
    run_a(1'b0, cyc(NP, 2, 4), "corners", 1'b0);
    chk("corners res_rd count", rd_a - rd0, 1030);
    chk("corners res_wr count", wr_a - wr0, 1026);
    chk("corner (0,0)", int'(res_a[0]), 1);
    chk("corner (31,31)", int'(res_a[NP - 1]), 1);

    // Abort a chessboard run mid forward pass, then rerun city-block on the cross.
    clear_img();
    put(20, 20, 2); put(19, 20, 1); put(21, 20, 1); put(20, 19, 1); put(20, 21, 1);
    pack_img();
    @(negedge clk);
    bus_a.mode  = 1'b0;
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (500) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort strobes", int'({bus_a.done, bus_a.sti_rd, bus_a.res_rd, bus_a.res_wr}), 0);
    chk("abort res_addr", int'(bus_a.res_addr), 0);
    chk("abort res_do", int'(bus_a.res_do), 0);
    repeat (2) @(negedge clk);
    chk("abort held strobes", int'({bus_a.done, bus_a.sti_rd, bus_a.res_rd, bus_a.res_wr}), 0);
    reset = 1'b1;
    run_a(1'b1, cyc(NP, 5, 2), "rerun city", 1'b1);
    chk("rerun centre", int'(res_a[20 * W + 20]), 2);

    @(negedge clk);
    bus_b.mode  = 1'b0;
    bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    n = 0;
    while (bus_b.done !== 1'b1 && n < 3073 + 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ones cycles", n, 3073);
    nmis = 0;
    for (int i = 0; i < NB; i++)
      if (int'(res_b[i]) != 7) nmis++;
    chk("ones map mismatches", nmis, 0);
    chk("ones (0,0)", int'(res_b[0]), 7);
    chk("ones (8,8)", int'(res_b[8 * WB + 8]), 7);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
